// File: rtl/instr_mem_responder_pkg.sv
// Shared constants for the compute-unit instruction-fetch path: fetcher and
// responder state encodings plus index-width helpers.
package instr_mem_responder_pkg;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_REQ  = 2'd1,
        F_WAIT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_BUSY = 2'd1,
        R_RESP = 2'd2
    } resp_state_e;

    localparam int LAT_CNT_WIDTH = 3;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/instr_mem_responder_rr_arbiter.sv
// Round-robin pick: first valid channel at or after rr_ptr_i, wrapping at NUM_CH.
module rr_arbiter
    import instr_mem_responder_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int IW     = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req_val_i,
    input  logic [IW-1:0]     rr_ptr_i,
    output logic [IW-1:0]     grant_o,
    output logic              any_valid_o
);

    logic [IW-1:0] idx;
    logic          found;

    // Explicit modulo keeps the wrap correct for non-power-of-two NUM_CH.
    always_comb begin
        grant_o = '0;
        idx     = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = IW'((int'(rr_ptr_i) + k) % NUM_CH);
            if (!found && req_val_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
        end
        any_valid_o = |req_val_i;
    end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: round-robin accepts one fetch at a time, reads the
// local instruction array after READ_LATENCY cycles, holds the response until taken.
module instr_mem_responder
    import instr_mem_responder_pkg::*;
#(
    parameter int PC_ADDR_WIDTH  = 8,
    parameter int INST_MSG_WIDTH = 16,
    parameter int NUM_CH         = 2,
    parameter int READ_LATENCY   = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_CH-1:0]               fetch_req_val,
    output logic [NUM_CH-1:0]               fetch_req_rdy,
    input  logic [NUM_CH*PC_ADDR_WIDTH-1:0] fetch_req_addr,
    output logic [NUM_CH-1:0]               fetch_resp_val,
    input  logic [NUM_CH-1:0]               fetch_resp_rdy,
    output logic [INST_MSG_WIDTH-1:0]       fetch_resp_inst,
    input  logic                            load_en,
    input  logic [PC_ADDR_WIDTH-1:0]        load_addr,
    input  logic [INST_MSG_WIDTH-1:0]       load_data,
    output logic                            busy
);

    localparam int IW    = idx_width(NUM_CH);
    localparam int DEPTH = 2 ** PC_ADDR_WIDTH;

    logic [INST_MSG_WIDTH-1:0] mem_q [DEPTH];

    resp_state_e               state_q, state_d;
    logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]             grant_ch_q, grant_ch_d;
    logic [LAT_CNT_WIDTH-1:0]  lat_cnt_q, lat_cnt_d;
    logic [PC_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [NUM_CH-1:0]         resp_val_q, resp_val_d;
    logic [INST_MSG_WIDTH-1:0] resp_inst_q, resp_inst_d;

    logic [IW-1:0]             grant;
    logic                      any_valid;
    logic                      accept;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_arb (
        .req_val_i   (fetch_req_val),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (grant),
        .any_valid_o (any_valid)
    );

    // Only the granted channel can see ready, so at most one handshake per cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            fetch_req_rdy[i] = (state_q == R_IDLE) && !load_en &&
                               (!any_valid || (grant == IW'(i)));
        end
    end

    assign accept = (state_q == R_IDLE) && !load_en && any_valid;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_ch_d  = grant_ch_q;
        lat_cnt_d   = lat_cnt_q;
        addr_d      = addr_q;
        resp_val_d  = resp_val_q;
        resp_inst_d = resp_inst_q;
        case (state_q)
            R_IDLE: begin
                if (accept) begin
                    addr_d     = fetch_req_addr[int'(grant)*PC_ADDR_WIDTH +: PC_ADDR_WIDTH];
                    grant_ch_d = grant;
                    lat_cnt_d  = LAT_CNT_WIDTH'(READ_LATENCY - 1);
                    rr_ptr_d   = IW'((int'(grant) + 1) % NUM_CH);
                    state_d    = R_BUSY;
                end
            end
            R_BUSY: begin
                // Array read is taken before this edge's load, so a same-cycle write is not seen.
                if (lat_cnt_q == '0) begin
                    resp_inst_d = mem_q[addr_q];
                    resp_val_d  = NUM_CH'(1) << grant_ch_q;
                    state_d     = R_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            R_RESP: begin
                if (fetch_resp_rdy[grant_ch_q]) begin
                    resp_val_d = '0;
                    state_d    = R_IDLE;
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= R_IDLE;
            rr_ptr_q    <= '0;
            grant_ch_q  <= '0;
            lat_cnt_q   <= '0;
            addr_q      <= '0;
            resp_val_q  <= '0;
            resp_inst_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_ch_q  <= grant_ch_d;
            lat_cnt_q   <= lat_cnt_d;
            addr_q      <= addr_d;
            resp_val_q  <= resp_val_d;
            resp_inst_q <= resp_inst_d;
        end
    end

    // Program storage is deliberately outside reset so a loaded kernel survives it.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
    end

    assign fetch_resp_val  = resp_val_q;
    assign fetch_resp_inst = resp_inst_q;
    assign busy            = (state_q != R_IDLE);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: idle ready/grant table plus sequences for
// latency, round-robin, response hold, load blocking/races and async reset.
module tb_instr_mem_responder;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int NCH   = 2;
    localparam int LAT_A = 2;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT a: READ_LATENCY = 2
    logic [NCH-1:0]    req_val, req_rdy, resp_val, resp_rdy;
    logic [NCH*AW-1:0] req_addr;
    logic [DW-1:0]     resp_inst;
    logic              load_en;
    logic [AW-1:0]     load_addr;
    logic [DW-1:0]     load_data;
    logic              busy;

    // DUT b: READ_LATENCY = 3
    logic [NCH-1:0]    req_val_b, req_rdy_b, resp_val_b, resp_rdy_b;
    logic [NCH*AW-1:0] req_addr_b;
    logic [DW-1:0]     resp_inst_b;
    logic              load_en_b;
    logic [AW-1:0]     load_addr_b;
    logic [DW-1:0]     load_data_b;
    logic              busy_b;

    instr_mem_responder #(
        .PC_ADDR_WIDTH(AW), .INST_MSG_WIDTH(DW), .NUM_CH(NCH), .READ_LATENCY(LAT_A)
    ) dut_a (
        .clk(clk), .reset(reset),
        .fetch_req_val(req_val), .fetch_req_rdy(req_rdy), .fetch_req_addr(req_addr),
        .fetch_resp_val(resp_val), .fetch_resp_rdy(resp_rdy), .fetch_resp_inst(resp_inst),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .busy(busy)
    );

    instr_mem_responder #(
        .PC_ADDR_WIDTH(AW), .INST_MSG_WIDTH(DW), .NUM_CH(NCH), .READ_LATENCY(LAT_B)
    ) dut_b (
        .clk(clk), .reset(reset),
        .fetch_req_val(req_val_b), .fetch_req_rdy(req_rdy_b), .fetch_req_addr(req_addr_b),
        .fetch_resp_val(resp_val_b), .fetch_resp_rdy(resp_rdy_b), .fetch_resp_inst(resp_inst_b),
        .load_en(load_en_b), .load_addr(load_addr_b), .load_data(load_data_b), .busy(busy_b)
    );

    // Valid/ready: a transfer happens on a rising edge where val and rdy are both high.
    // Requesters drop val on their handshake edge; responses are taken with resp_rdy.

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] exp_inst;

    typedef struct {
        logic [1:0] val;
        logic       ld;
        logic [1:0] exp_rdy;
        string      name;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic load_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
        load_en_b = 1'b1; load_addr_b = a; load_data_b = d;
        tick();
        load_en_b = 1'b0;
    endtask

    // Single fetch on dut a, from idle through acknowledgement.
    task automatic fetch_a(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input string name);
        req_val  = '0;
        req_val[ch] = 1'b1;
        req_addr[ch*AW +: AW] = a;
        #1;
        check({name, "_rdy"}, 32'(req_rdy[ch]), 32'd1);
        tick();
        req_val = '0;
        exp_q.push_back(d);
        for (int k = 0; k < LAT_A; k++) begin
            check({name, "_val_wait"}, 32'(resp_val), 32'd0);
            check({name, "_busy"}, 32'(busy), 32'd1);
            tick();
        end
        exp_inst = exp_q.pop_front();
        check({name, "_val"}, 32'(resp_val), 32'(2'b01 << ch));
        check({name, "_inst"}, 32'(resp_inst), 32'(exp_inst));
        resp_rdy[ch] = 1'b1;
        tick();
        resp_rdy = '0;
        check({name, "_val_clr"}, 32'(resp_val), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{val: 2'b00, ld: 1'b0, exp_rdy: 2'b11, name: "tbl_none"};
        vecs[1] = '{val: 2'b01, ld: 1'b0, exp_rdy: 2'b01, name: "tbl_ch0"};
        vecs[2] = '{val: 2'b10, ld: 1'b0, exp_rdy: 2'b10, name: "tbl_ch1"};
        vecs[3] = '{val: 2'b11, ld: 1'b0, exp_rdy: 2'b01, name: "tbl_both"};
        vecs[4] = '{val: 2'b00, ld: 1'b1, exp_rdy: 2'b00, name: "tbl_ld_none"};
        vecs[5] = '{val: 2'b01, ld: 1'b1, exp_rdy: 2'b00, name: "tbl_ld_ch0"};
        vecs[6] = '{val: 2'b11, ld: 1'b1, exp_rdy: 2'b00, name: "tbl_ld_both"};

        reset = 1'b0;
        req_val = '0; resp_rdy = '0; req_addr = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        req_val_b = '0; resp_rdy_b = '0; req_addr_b = '0;
        load_en_b = 1'b0; load_addr_b = '0; load_data_b = '0;
        #2;
        check("rst_resp_val", 32'(resp_val), 32'd0);
        check("rst_resp_inst", 32'(resp_inst), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rdy", 32'(req_rdy), 32'b11);
        check("rst_busy_b", 32'(busy_b), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Idle ready/grant table with rr_ptr=0; inputs withdrawn before each edge.
        for (int i = 0; i < 7; i++) begin
            req_val = vecs[i].val;
            load_en = vecs[i].ld;
            load_addr = 8'hFF;
            load_data = 16'hDEAD;
            #1;
            check(vecs[i].name, 32'(req_rdy), 32'(vecs[i].exp_rdy));
            check({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
            #1;
            req_val = '0;
            load_en = 1'b0;
            tick();
        end

        load_a(8'h10, 16'hBEEF);
        load_a(8'h01, 16'h0101);
        load_a(8'h02, 16'h0202);

        // Basic latency: ch0 reads 0x10.
        fetch_a(0, 8'h10, 16'hBEEF, "basic");

        // rr_ptr now 1: ch1 wins, ch0 waits; hold ch1's response for 5 cycles.
        req_val  = 2'b11;
        req_addr = {8'h02, 8'h01};
        #1;
        check("rr1_rdy", 32'(req_rdy), 32'b10);
        tick();
        req_val = 2'b01;
        exp_q.push_back(16'h0202);
        #1;
        check("rr1_busy_rdy", 32'(req_rdy), 32'b00);
        tick();
        tick();
        check("hold_val0", 32'(resp_val), 32'b10);
        check("hold_inst0", 32'(resp_inst), 32'(exp_q[0]));
        resp_rdy = 2'b01;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_val", 32'(resp_val), 32'b10);
            check("hold_inst", 32'(resp_inst), 32'(exp_q[0]));
            check("hold_busy", 32'(busy), 32'd1);
            check("hold_rdy", 32'(req_rdy), 32'b00);
        end
        resp_rdy = 2'b10;
        tick();
        resp_rdy = '0;
        void'(exp_q.pop_front());
        check("hold_clr", 32'(resp_val), 32'd0);

        // rr_ptr back to 0, both valid: ch0 first, then ch1.
        req_val = 2'b11;
        #1;
        check("both_rdy0", 32'(req_rdy), 32'b01);
        tick();
        req_val = 2'b10;
        #1;
        check("both_ch1_blocked", 32'(req_rdy), 32'b00);
        tick();
        tick();
        check("both_val0", 32'(resp_val), 32'b01);
        check("both_inst0", 32'(resp_inst), 32'h0101);
        resp_rdy = 2'b01;
        #1;
        check("both_resp_rdy", 32'(req_rdy), 32'b00);
        tick();
        resp_rdy = '0;
        check("both_clr0", 32'(resp_val), 32'd0);
        check("both_rdy1", 32'(req_rdy), 32'b10);
        tick();
        req_val = '0;
        tick();
        tick();
        check("both_val1", 32'(resp_val), 32'b10);
        check("both_inst1", 32'(resp_inst), 32'h0202);
        resp_rdy = 2'b10;
        tick();
        resp_rdy = '0;
        req_val = 2'b11;
        #1;
        check("both_ptr_end", 32'(req_rdy), 32'b01);
        #1;
        req_val = '0;
        tick();

        // Load in idle blocks accept; dropping it lets ch0 in next edge.
        req_val = 2'b01;
        req_addr[7:0] = 8'h10;
        load_en = 1'b1; load_addr = 8'h30; load_data = 16'h3333;
        #1;
        check("ldblk_rdy", 32'(req_rdy), 32'b00);
        tick();
        check("ldblk_busy", 32'(busy), 32'd0);
        load_en = 1'b0;
        #1;
        check("ldblk_rdy_after", 32'(req_rdy), 32'b01);
        tick();
        req_val = '0;
        check("ldblk_accept", 32'(busy), 32'd1);
        tick();
        tick();
        check("ldblk_inst", 32'(resp_inst), 32'hBEEF);
        resp_rdy = 2'b01;
        tick();
        resp_rdy = '0;
        fetch_a(1, 8'h30, 16'h3333, "ld_in_idle");

        // dut b: load on the cycle after accept is seen by the response.
        load_b(8'h20, 16'h1111);
        req_val_b = 2'b01;
        req_addr_b = {8'h00, 8'h20};
        tick();
        req_val_b = '0;
        load_en_b = 1'b1; load_addr_b = 8'h20; load_data_b = 16'h2222;
        tick();
        load_en_b = 1'b0;
        check("race1_wait1", 32'(resp_val_b), 32'd0);
        tick();
        check("race1_wait2", 32'(resp_val_b), 32'd0);
        tick();
        check("race1_val", 32'(resp_val_b), 32'b01);
        check("race1_inst", 32'(resp_inst_b), 32'h2222);
        resp_rdy_b = 2'b01;
        tick();
        resp_rdy_b = '0;

        // dut b: load on the final countdown cycle returns the old word.
        load_b(8'h20, 16'h1111);
        req_val_b = 2'b01;
        tick();
        req_val_b = '0;
        tick();
        tick();
        load_en_b = 1'b1; load_addr_b = 8'h20; load_data_b = 16'h2222;
        tick();
        load_en_b = 1'b0;
        check("race2_val", 32'(resp_val_b), 32'b01);
        check("race2_inst", 32'(resp_inst_b), 32'h1111);
        resp_rdy_b = 2'b01;
        tick();
        resp_rdy_b = '0;
        req_val_b = 2'b01;
        tick();
        req_val_b = '0;
        tick();
        tick();
        tick();
        check("race2_after_val", 32'(resp_val_b), 32'b01);
        check("race2_after_inst", 32'(resp_inst_b), 32'h2222);
        resp_rdy_b = 2'b01;
        tick();
        resp_rdy_b = '0;

        // Async reset during R_BUSY drops the transaction.
        req_val = 2'b01;
        req_addr[7:0] = 8'h10;
        tick();
        req_val = '0;
        check("rstb_busy_pre", 32'(busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("rstb_busy", 32'(busy), 32'd0);
        check("rstb_val", 32'(resp_val), 32'd0);
        tick();
        #2;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rstb_no_resp", 32'(resp_val), 32'd0);
            check("rstb_idle", 32'(busy), 32'd0);
        end

        // Async reset while holding a response clears it at once.
        req_val = 2'b01;
        tick();
        req_val = '0;
        tick();
        tick();
        check("rstr_val_pre", 32'(resp_val), 32'b01);
        #1;
        reset = 1'b0;
        #1;
        check("rstr_val", 32'(resp_val), 32'd0);
        check("rstr_inst", 32'(resp_inst), 32'd0);
        #2;
        reset = 1'b1;
        tick();
        req_val = 2'b11;
        #1;
        check("rstr_ptr", 32'(req_rdy), 32'b01);
        #1;
        req_val = '0;
        tick();
        fetch_a(0, 8'h10, 16'hBEEF, "mem_survives");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected done");
        $fatal(1, "timeout");
    end

endmodule
